// File: rtl/addr_to_pixel.sv
// addr_to_pixel: framebuffer byte address -> (x, y) screen coordinates.
// Range/alignment check, then restoring divide by H_RES, one bit per cycle.
module addr_to_pixel #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BPP_SHIFT = 2,
    parameter int PIX_W     = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  x,
    output logic [9:0]  y
);
    localparam int RW = $clog2(H_RES) + 1;
    localparam int CW = $clog2(PIX_W);
    localparam logic [31:0]   FRAME = 32'(H_RES * V_RES);
    localparam logic [RW-1:0] DIVR  = RW'(H_RES);
    localparam logic [CW-1:0] LAST  = CW'(PIX_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [32:0]       r_diff;
    logic [PIX_W-1:0]  r_div;
    logic [RW-2:0]     r_rem;
    logic [CW-1:0]     r_cnt;

    logic [31-BPP_SHIFT:0] w_pix;
    logic                  w_bad;
    logic [RW-1:0]         w_rem_sh;
    logic                  w_ge;
    logic [RW-2:0]         w_rem_nx;
    logic [PIX_W-1:0]      w_quo;

    assign w_pix    = r_diff[31:BPP_SHIFT];
    assign w_bad    = r_diff[32]
                    | (|r_diff[BPP_SHIFT-1:0])
                    | (32'(w_pix) >= FRAME);
    // Dividend register doubles as the quotient: bits shift in at the LSB.
    assign w_rem_sh = {r_rem, r_div[PIX_W-1]};
    assign w_ge     = (w_rem_sh >= DIVR);
    assign w_rem_nx = (RW-1)'(w_ge ? w_rem_sh - DIVR : w_rem_sh);
    assign w_quo    = {r_div[PIX_W-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_diff  <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            x       <= '0;
            y       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_diff  <= {1'b0, addr} - {1'b0, base};
                        busy    <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        err     <= 1'b1;
                        x       <= '0;
                        y       <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_div   <= w_pix[PIX_W-1:0];
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        err     <= 1'b0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_div <= w_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        x       <= 10'(w_rem_nx);
                        y       <= 10'(w_quo);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
